phase_timer: RTL
================

Name: phase_timer

Overview:
- Countdown timer datapath that the traffic-light state machine sequences. It loads a phase duration on the controller's one-cycle load strobes, counts down once per second, and returns `rest_time` to the controller.
- Supports pause, a save/restore path for online override, and registered BCD digits for the two-digit display.
- Sits between the light controller and the seven-segment display driver.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s tick (benches use 4).
- TW, 7, width of all time values.
- MAX_T, 99, saturation ceiling for any loaded value (two display digits).
- DEF_RED, 30, red duration after reset.
- DEF_GREEN, 25, green duration after reset.
- DEF_YELLOW, 3, yellow duration after reset.
- FIVE_T, 5, pedestrian-green duration.
- EIGHT_T, 8, pedestrian-red duration.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- red_s  in  1  load red duration (one-cycle strobe).
- yellow_s  in  1  load yellow duration.
- green_s  in  1  load green duration.
- five_time  in  1  load FIVE_T.
- eight_time  in  1  load EIGHT_T.
- save_s  in  1  load restore_time (return from online override).
- init_s  in  1  clear count to 0 and restart prescaler.
- pause  in  1  freeze countdown and prescaler.
- restore_time  in  TW  value saved by controller (p_rest_time).
- cfg_we  in  1  write duration config.
- cfg_sel  in  2  0 = red, 1 = green, 2 = yellow, 3 = ignored.
- cfg_val  in  TW  new duration.
- rest_time  out  TW  remaining seconds.
- rest_tens  out  4  BCD tens of rest_time.
- rest_ones  out  4  BCD ones of rest_time.
- tick  out  1  one-cycle pulse per second.
- expired  out  1  one-cycle pulse on the 1 -> 0 transition.

Behaviour:
- Reset (async, rst_n = 0):
  - rest_time = 0, rest_tens = 0, rest_ones = 0, tick = 0, expired = 0.
  - Prescaler = TICK_DIV-1.
  - Config registers = DEF_RED / DEF_GREEN / DEF_YELLOW.
  - Release is synchronous to clk; the first edge after release behaves normally.
- Prescaler:
  - Down-counter, stepped while pause = 0.
  - At 0 with pause = 0: reloads TICK_DIV-1 and tick = 1 for that cycle.
  - While paused it holds its value; tick stays 0.
- Load, registered, visible one cycle after the strobe edge.
  - Priority when strobes coincide: save_s > init_s > green_s > yellow_s > red_s > five_time > eight_time.
  - Loaded value = min(source, MAX_T).
  - A config value of 0 is loaded as 1, so every phase lasts at least one tick.
  - Any load also reloads the prescaler to TICK_DIV-1, so the first decrement comes exactly TICK_DIV cycles after the strobe edge.
  - A load in the same cycle as a tick wins; no decrement occurs.
  - Loads act even while pause = 1.
- Countdown:
  - On tick, with no load pending and rest_time != 0: rest_time decrements by 1.
  - At 0 it holds; no wrap-around.
  - expired = 1 for the one cycle after rest_time goes 1 -> 0 by decrement.
  - A load to 0 (init_s, save_s with 0) does not assert expired.
- Config writes:
  - On cfg_we, cfg_val (saturated to MAX_T) is stored in the selected register.
  - Writes affect only later loads, never the running count.
  - A write and a load of the same phase in one cycle: the load uses the old value.
- BCD outputs:
  - rest_tens and rest_ones are registered from the next-state count, so they are always coherent with rest_time in the same cycle.
  - Conversion is by constant divide-by-10 or double-dabble; TW = 7 with MAX_T = 99 guarantees tens <= 9.
- Controller contract:
  - After a strobe, rest_time is nonzero by the time the controller re-enters its steady state (two cycles later).
  - The controller leaves that state when it samples rest_time == 0.
- Reset mid-count forces all outputs to their reset values immediately, independent of clk.

Decomposition:
- Package `traffic_pkg` holds:
  - TW, MAX_T, DEF_RED / DEF_GREEN / DEF_YELLOW, FIVE_T, EIGHT_T.
  - cfg_sel encodings CFG_RED = 0, CFG_GREEN = 1, CFG_YELLOW = 2.
  - Shared with the light controller.
- Sub-module `tick_prescaler` (params TICK_DIV): inputs clk, rst_n, en, restart; output tick.
- Load mux, countdown register and BCD conversion stay in `phase_timer`.

Test Plan (TICK_DIV = 4):
1. Reset, then green_s at cycle 10 -> rest_time = 25 at cycle 11; 24 after cycle 14; reaches 0 after 100 cycles with a single expired pulse; rest_tens/ones track (2,5) -> (0,0).
2. yellow_s, then pause = 1 for 20 cycles after the first tick -> rest_time holds 2 and tick stays 0 while paused; 1 -> 0 resumes exactly 4 cycles per step after release.
3. red_s and green_s in the same cycle -> 25 loaded; save_s with restore_time = 17 alongside eight_time -> 17 loaded.
4. cfg_we sel = 0 val = 120 during a green count -> green count unaffected; next red_s loads 99, BCD (9,9); cfg val = 0 then red_s -> loads 1.
5. Load coincident with the tick cycle -> loaded value kept, first decrement 4 cycles later; init_s -> 0 with no expired pulse.
6. rst_n low asynchronously mid-count at rest_time = 13 -> all outputs 0 before the next edge; config returns to defaults (red_s loads 30).

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic-light controller
// and its phase timer.
package traffic_pkg;

   localparam int TW         = 7;
   localparam int MAX_T      = 99;
   localparam int DEF_RED    = 30;
   localparam int DEF_GREEN  = 25;
   localparam int DEF_YELLOW = 3;
   localparam int FIVE_T     = 5;
   localparam int EIGHT_T    = 8;

   typedef enum logic [1:0] {
      CFG_RED    = 2'd0,
      CFG_GREEN  = 2'd1,
      CFG_YELLOW = 2'd2
   } cfg_sel_e;

   // clamp a time value to the two-digit display range
   function automatic logic [TW-1:0] sat_t(input logic [TW-1:0] v);
      return (v > TW'(MAX_T)) ? TW'(MAX_T) : v;
   endfunction

   // a phase always lasts at least one tick
   function automatic logic [TW-1:0] min_one(input logic [TW-1:0] v);
      return (v == '0) ? TW'(1) : v;
   endfunction

   // {tens, ones} of a value known to be <= 99
   function automatic logic [7:0] to_bcd(input logic [TW-1:0] v);
      return {4'(v / TW'(10)), 4'(v % TW'(10))};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: a down-counter that pulses tick
// when it wraps, freezes while disabled and reloads on restart.
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == '0);

   // count down, reloading on wrap or on a phase load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= TOP;
      end else if (restart || tick) begin
         cnt <= TOP;
      end else if (en) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/phase_timer.sv
// Phase countdown datapath: load mux, per-second countdown,
// duration config registers and registered BCD display digits.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          red_s,
   input  logic          yellow_s,
   input  logic          green_s,
   input  logic          five_time,
   input  logic          eight_time,
   input  logic          save_s,
   input  logic          init_s,
   input  logic          pause,
   input  logic [TW-1:0] restore_time,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [TW-1:0] cfg_val,
   output logic [TW-1:0] rest_time,
   output logic [3:0]    rest_tens,
   output logic [3:0]    rest_ones,
   output logic          tick,
   output logic          expired
);

   logic [TW-1:0] cfg_red;
   logic [TW-1:0] cfg_green;
   logic [TW-1:0] cfg_yellow;
   logic          load;
   logic [TW-1:0] load_val;
   logic [TW-1:0] next_rest;
   logic          hit_zero;

   assign load = save_s | init_s | green_s | yellow_s |
                 red_s | five_time | eight_time;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!pause),
      .restart (load),
      .tick    (tick)
   );

   // select the load source by strobe priority
   always_comb begin
      load_val = '0;
      priority case (1'b1)
         save_s:     load_val = sat_t(restore_time);
         init_s:     load_val = '0;
         green_s:    load_val = min_one(cfg_green);
         yellow_s:   load_val = min_one(cfg_yellow);
         red_s:      load_val = min_one(cfg_red);
         five_time:  load_val = TW'(FIVE_T);
         eight_time: load_val = TW'(EIGHT_T);
         default:    load_val = '0;
      endcase
   end

   // next count: a load beats a tick; the count stops at zero
   always_comb begin
      next_rest = rest_time;
      hit_zero  = 1'b0;
      if (load) begin
         next_rest = load_val;
      end else if (tick && rest_time != '0) begin
         next_rest = rest_time - TW'(1);
         hit_zero  = (rest_time == TW'(1));
      end
   end

   // count, display digits and expiry pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rest_time <= '0;
         rest_tens <= '0;
         rest_ones <= '0;
         expired   <= 1'b0;
      end else begin
         rest_time              <= next_rest;
         {rest_tens, rest_ones} <= to_bcd(next_rest);
         expired                <= hit_zero;
      end
   end

   // duration config; only later loads see a new value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_red    <= TW'(DEF_RED);
         cfg_green  <= TW'(DEF_GREEN);
         cfg_yellow <= TW'(DEF_YELLOW);
      end else if (cfg_we) begin
         if (cfg_sel == CFG_RED)    cfg_red    <= sat_t(cfg_val);
         if (cfg_sel == CFG_GREEN)  cfg_green  <= sat_t(cfg_val);
         if (cfg_sel == CFG_YELLOW) cfg_yellow <= sat_t(cfg_val);
      end
   end

endmodule
